// File: rtl/multdiv_iterative.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_iterative
// Brief    : Multi-cycle signed 32-bit multiply (Booth) / divide (non-restoring)
//            unit. Define MULTDIV_RADIX4_EN for radix-4 Booth (16 iterations).
// Revision : 1.0
// ============================================================================
module multdiv_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int PW = 2*WIDTH + 3;

`ifdef MULTDIV_RADIX4_EN
    localparam logic [4:0] c_MULT_LAST = 5'd15;
`else
    localparam logic [4:0] c_MULT_LAST = 5'd31;
`endif
    localparam logic [4:0] c_DIV_LAST = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [4:0]         r_cnt;
    logic               w_start_mult;
    logic               w_start_div;
    logic               w_last;

    logic [WIDTH-1:0]   r_mcand;
    logic [PW-1:0]      r_prod;
    logic [WIDTH+1:0]   w_mc;
    logic [WIDTH+1:0]   w_addend;
    logic [WIDTH+1:0]   w_upper_sum;
    logic [PW-1:0]      w_prod_next;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_exc;

    logic [WIDTH+1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_qneg;
    logic               r_dz;
    logic [WIDTH+1:0]   w_rem_sh;
    logic [WIDTH+1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_div_res;
    logic               w_div_exc;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_mult = 1'b0;
        w_start_div  = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_start_mult = ctrl_MULT;
                w_start_div  = ctrl_DIV & ~ctrl_MULT;
                if (w_start_mult) begin
                    w_state_next = S_MULT;
                end else if (w_start_div) begin
                    w_state_next = S_DIV;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_MULT: begin
                w_last = (r_cnt == c_MULT_LAST);
                if (w_last) w_state_next = S_DONE;
            end
            S_DIV: begin
                w_last = r_dz | (r_cnt == c_DIV_LAST);
                if (w_last) w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy           = (r_state == S_MULT) || (r_state == S_DIV);
    assign data_resultRDY = (r_state == S_DONE);

    // Booth step: accumulator upper part carries two guard bits so +/-2A never overflows
    always_comb begin
        w_mc     = {{2{r_mcand[WIDTH-1]}}, r_mcand};
        w_addend = '0;
`ifdef MULTDIV_RADIX4_EN
        case (r_prod[2:0])
            3'b001, 3'b010: w_addend = w_mc;
            3'b011:         w_addend = w_mc << 1;
            3'b100:         w_addend = ~(w_mc << 1) + 1'b1;
            3'b101, 3'b110: w_addend = ~w_mc + 1'b1;
            default:        w_addend = '0;
        endcase
        w_upper_sum = r_prod[PW-1:WIDTH+1] + w_addend;
        w_prod_next = $signed({w_upper_sum, r_prod[WIDTH:0]}) >>> 2;
`else
        case (r_prod[1:0])
            2'b01:   w_addend = w_mc;
            2'b10:   w_addend = ~w_mc + 1'b1;
            default: w_addend = '0;
        endcase
        w_upper_sum = r_prod[PW-1:WIDTH+1] + w_addend;
        w_prod_next = $signed({w_upper_sum, r_prod[WIDTH:0]}) >>> 1;
`endif
        w_prod_hi = w_prod_next[2*WIDTH:WIDTH];
        w_mul_exc = ~((&w_prod_hi) | ~(|w_prod_hi));
    end

    // Non-restoring step; the final remainder is discarded so no correction step is needed
    always_comb begin
        w_rem_sh   = {r_rem[WIDTH:0], r_quo[WIDTH-1]};
        w_rem_next = r_rem[WIDTH+1] ? (w_rem_sh + {2'b00, r_dvs})
                                    : (w_rem_sh - {2'b00, r_dvs});
        w_quo_next = {r_quo[WIDTH-2:0], ~w_rem_next[WIDTH+1]};
        w_div_res  = r_qneg ? (~w_quo_next + 1'b1) : w_quo_next;
        w_div_exc  = ~r_qneg & w_quo_next[WIDTH-1];
        // |0x80000000| = 2^31 still fits as an unsigned 32-bit magnitude
        w_mag_a    = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        w_mag_b    = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt          <= '0;
            r_mcand        <= '0;
            r_prod         <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_dvs          <= '0;
            r_qneg         <= 1'b0;
            r_dz           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (w_start_mult) begin
            r_cnt   <= '0;
            r_mcand <= data_operandA;
            r_prod  <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
        end else if (w_start_div) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= w_mag_a;
            r_dvs  <= w_mag_b;
            r_qneg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dz   <= (data_operandB == '0);
        end else if (r_state == S_MULT) begin
            r_cnt  <= r_cnt + 5'd1;
            r_prod <= w_prod_next;
            if (w_last) begin
                data_result    <= w_prod_next[WIDTH:1];
                data_exception <= w_mul_exc;
            end
        end else if (r_state == S_DIV) begin
            r_cnt <= r_cnt + 5'd1;
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            if (r_dz) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end else if (w_last) begin
                data_result    <= w_div_res;
                data_exception <= w_div_exc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_iterative.sv
`default_nettype none
// Scoreboard bench for multdiv_iterative: directed vectors, expected results
// and strobe cycles queued at issue time, checked by an independent monitor.
module tb_multdiv_iterative;

`ifdef MULTDIV_RADIX4_EN
    localparam int LAT_MULT = 16;
`else
    localparam int LAT_MULT = 32;
`endif
    localparam int LAT_DIV = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    multdiv_iterative dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: strobe at cycle %0d with no operation pending", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, data_result, e.res);
                check({e.name, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
                check({e.name, "_cycle"}, cyc, e.cyc);
                check({e.name, "_busy_low"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    // Called at a negedge; returns just after the start edge E0
    task automatic start_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input logic exc, input int lat,
                            input string name);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = is_mult;
        ctrl_DIV      = !is_mult;
        e.res  = res;
        e.exc  = exc;
        e.cyc  = cyc + 1 + lat;
        e.name = name;
        sb.push_back(e);
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        check({name, "_busy_start"}, {31'd0, busy}, 32'd1);
    endtask

    // Returns at the negedge of the strobe cycle
    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (data_resultRDY !== 1'b1 && n < 100);
        if (data_resultRDY !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no strobe within %0d cycles, expected one", name, n);
            sb.delete();
        end
    endtask

    task automatic do_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input int lat,
                         input string name);
        start_op(is_mult, a, b, res, exc, lat, name);
        wait_done(name);
        @(negedge clock);
        check({name, "_strobe_single"}, {31'd0, data_resultRDY}, 32'd0);
        check({name, "_hold"}, data_result, res);
    endtask

    task automatic idle_window(input int n, input string name);
        int cnt;
        cnt = 0;
        repeat (n) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) cnt++;
        end
        check({name, "_no_strobe"}, cnt, 0);
    endtask

    initial begin
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_result", data_result, 32'd0);
        check("rst_exception", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        idle_window(50, "idle");

        do_op(1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, LAT_MULT, "mul_7xm3");
        do_op(1'b1, 32'h00010000, 32'h00010000, 32'h0, 1'b1, LAT_MULT, "mul_ovf");
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, LAT_MULT, "mul_minxm1");
        do_op(1'b1, 32'h80000000, 32'd1, 32'h80000000, 1'b0, LAT_MULT, "mul_minx1");
        do_op(1'b0, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, LAT_DIV, "div_m100d7");
        do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, LAT_DIV, "div_ovf");
        do_op(1'b0, 32'h80000000, 32'd2, 32'hC0000000, 1'b0, LAT_DIV, "div_min_d2");
        do_op(1'b0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, LAT_DIV, "div_7dm2");
        do_op(1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 1'b0, LAT_DIV, "div_m7dm2");
        do_op(1'b0, 32'd5, 32'd0, 32'd0, 1'b1, 1, "div_by0");

        // Starts and operand changes while busy must be ignored
        start_op(1'b1, 32'd3, 32'd4, 32'd12, 1'b0, LAT_MULT, "mul_3x4");
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'h55; data_operandB = 32'h0;
        @(negedge clock);
        ctrl_DIV = 1'b0; ctrl_MULT = 1'b1; data_operandA = 32'h1234;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_done("mul_3x4");
        // Back-to-back: start issued during the strobe cycle
        do_op(1'b1, 32'hFFFFFFFB, 32'd6, 32'hFFFFFFE2, 1'b0, LAT_MULT, "mul_b2b");

        // Reset at E10 of a multiply aborts without a strobe
        data_operandA = 32'd9; data_operandB = 32'd9; ctrl_MULT = 1'b1;
        @(posedge clock);
        #1 ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("abort_result", data_result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle_window(40, "abort");
        do_op(1'b1, 32'd2, 32'd2, 32'd4, 1'b0, LAT_MULT, "mul_2x2");

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/multdiv_iterative.md
Name: multdiv_iterative

Overview:
- Multi-cycle signed multiply/divide unit in the execute stage. Sits beside the single-cycle ALU bitwise/add units and consumes the same operand buses from the D/X latch.
- Started by a one-cycle control pulse. Raises a ready strobe when the 32-bit result is valid. The pipeline stalls on `busy` until then.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high. Clears all state to IDLE.
- data_operandA  in  32  multiplicand / dividend, two's complement.
- data_operandB  in  32  multiplier / divisor, two's complement.
- ctrl_MULT  in  1  start-multiply pulse, sampled on the clock edge.
- ctrl_DIV  in  1  start-divide pulse, sampled on the clock edge.
- data_result  out  32  low 32 bits of the product, or the quotient.
- data_exception  out  1  overflow or divide-by-zero flag. Valid when data_resultRDY=1 and held afterwards.
- data_resultRDY  out  1  one-cycle strobe marking data_result as valid.
- busy  out  1  high from the start edge until the edge that raises data_resultRDY.

Behaviour:
- Reset values:
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - State=IDLE, iteration counter=0.
  - Reset mid-operation aborts immediately. No strobe is generated for the aborted operation.
- States and transitions:
  - IDLE → MULT on ctrl_MULT, or → DIV on ctrl_DIV.
  - MULT/DIV → DONE when counter reaches terminal count.
  - DONE → IDLE, or directly to MULT/DIV if a new start is sampled in DONE.
- Start: operands are latched on the start edge (E0). Later operand changes are ignored.
- Start rules:
  - If ctrl_MULT and ctrl_DIV are both high, multiply wins.
  - Start pulses are ignored while busy=1.
- Multiply:
  - Radix-2 Booth algorithm, 64-bit product register, one iteration per cycle, 32 iterations.
  - data_resultRDY=1 in the cycle after edge E32. busy=1 from E0 through E31, and drops at E32.
  - data_result = product[31:0].
  - data_exception=1 iff product[63:31] is not all-0 and not all-1, i.e. the result does not fit in 32 signed bits.
- Divide:
  - Non-restoring divide on magnitudes, 32 iterations; resultRDY timing identical to multiply.
  - Quotient is truncated toward zero. Quotient sign = signA XOR signB; the remainder is discarded.
  - Divisor == 0: detected at E0. DONE is entered at E1, so resultRDY is high in the cycle after E1. data_result=0, data_exception=1.
  - 0x80000000 / 0xFFFFFFFF: full latency, data_result=0x80000000, data_exception=1.
  - Dividend 0x80000000 with any other divisor: correct result. Magnitude handling uses 33 bits internally.
- Output holding:
  - data_result and data_exception hold their values after the strobe until the next DONE or reset.
  - data_resultRDY is never high for two consecutive cycles for the same operation.
- Back-to-back: a start sampled in the same cycle as data_resultRDY=1 is accepted. The new op latches at that edge.

Optional Feature:
- Macro: MULTDIV_RADIX4_EN.
- Defined: multiply uses radix-4 Booth with two multiplier bits per iteration and 16 iterations.
  - Multiply resultRDY is in the cycle after E16; busy drops at E16.
  - Divide latency and all results/exceptions are unchanged.
- Undefined: radix-2 Booth as described under Behaviour.

Test Plan:
- Reset held for 2 cycles, then released → all outputs 0 and busy=0. No strobe appears for 50 cycles without a start.
- MULT A=7, B=-3 → resultRDY after E32 (E16 with the macro), result=0xFFFFFFEB, exception=0. Also MULT 0x00010000×0x00010000 → result=0, exception=1.
- DIV A=-100, B=7 → result=0xFFFFFFF2 (-14), exception=0, strobe after E32. DIV 0x80000000/-1 → 0x80000000, exception=1.
- DIV A=5, B=0 → strobe after E1, result=0, exception=1.
- Start MULT 3×4 and re-pulse ctrl_DIV while busy; change operands after E0 → ignored, result=12. Then assert a start in the strobe cycle → accepted, new result appears 33 edges later.
- Assert reset at E10 of a multiply → no strobe, busy=0 next cycle. A new MULT 2×2 → result=4.
